// File: rtl/imem_fetch_controller_if.sv
// imem_fetch_controller_if: bundles the loader, instruction-memory, redirect
// and decode-handshake signals of imem_fetch_controller.
//   master : controller side (drives memory port, ld_ack, ins_*, state_o)
//   slave  : environment side (loader, memory, execute, decode)
interface imem_fetch_controller_if;
  logic        start;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_ack;
  logic [31:0] imem_A;
  logic        imem_WE;
  logic [31:0] imem_WD;
  logic [31:0] imem_RD;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ins_valid;
  logic [31:0] ins_data;
  logic [31:0] ins_pc;
  logic        ins_ready;
  logic [1:0]  state_o;

  modport master (
    input  start, ld_req, ld_addr, ld_data, imem_RD, redirect, redirect_pc, ins_ready,
    output ld_ack, imem_A, imem_WE, imem_WD, ins_valid, ins_data, ins_pc, state_o
  );

  modport slave (
    output start, ld_req, ld_addr, ld_data, imem_RD, redirect, redirect_pc, ins_ready,
    input  ld_ack, imem_A, imem_WE, imem_WD, ins_valid, ins_data, ins_pc, state_o
  );
endinterface

// File: rtl/imem_fetch_controller.sv
// imem_fetch_controller: sequences the single-port instruction memory.
// Fetches sequential words into a DEPTH-entry {pc, instr} prefetch queue that
// feeds decode over valid/ready; a redirect flushes the queue and restarts
// fetch; a program loader takes the memory port with absolute priority.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus (master)  : start, ld_req/ld_addr/ld_data/ld_ack loader port,
//                   imem_A/WE/WD/RD memory port, redirect/redirect_pc,
//                   ins_valid/ins_data/ins_pc/ins_ready decode port, state_o
// Parameters: DEPTH (power of two, >= 2), RESET_PC.
// Optional: define IMEM_HALT_EN to stop fetching after an ebreak is pushed
// (HALT state, left only by redirect, ld_req or rst).
module imem_fetch_controller #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                   clk,
  input logic                   rst,
  imem_fetch_controller_if.master bus
);

  localparam int unsigned   AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW   = $clog2(DEPTH + 1);
  localparam logic [31:0]   PC0  = {RESET_PC[31:2], 2'b00};
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
`ifdef IMEM_HALT_EN
  localparam logic [31:0]   EBREAK = 32'h0010_0073;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LOAD  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [31:0]   fetch_pc, fetch_pc_n;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   q_pc  [DEPTH];
  logic [31:0]   q_ins [DEPTH];
  logic          push, pop, flush;

  // Next state, fetch address and queue control.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    push       = 1'b0;
    flush      = 1'b0;
    pop        = (count != '0) && bus.ins_ready;
    unique case (state)
      S_IDLE: begin
        if (bus.ld_req) begin
          state_n = S_LOAD;
          flush   = 1'b1;
        end else if (bus.start) begin
          state_n    = S_FETCH;
          fetch_pc_n = PC0;
        end
      end
      S_FETCH: begin
        if (bus.ld_req) begin
          state_n = S_LOAD;
          flush   = 1'b1;
        end else if (bus.redirect) begin
          flush      = 1'b1;
          fetch_pc_n = bus.redirect_pc & ~32'h3;
        end else if (count != FULL || pop) begin
          // A full queue can still accept a word when the head leaves this cycle.
          push       = 1'b1;
          fetch_pc_n = fetch_pc + 32'd4;
`ifdef IMEM_HALT_EN
          if (bus.imem_RD == EBREAK) state_n = S_HALT;
`endif
        end
      end
      S_LOAD: begin
        flush = 1'b1;
        if (!bus.ld_req) begin
          state_n    = S_IDLE;
          fetch_pc_n = PC0;
        end
      end
      S_HALT: begin
        if (bus.ld_req) begin
          state_n = S_LOAD;
          flush   = 1'b1;
        end else if (bus.redirect) begin
          state_n    = S_FETCH;
          flush      = 1'b1;
          fetch_pc_n = bus.redirect_pc & ~32'h3;
        end
      end
    endcase
    // A flush discards the head, so a concurrent pop has no effect.
    if (flush) pop = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      fetch_pc <= PC0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_pc[i]  <= '0;
        q_ins[i] <= '0;
      end
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      if (flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          q_pc[wr_ptr]  <= fetch_pc;
          q_ins[wr_ptr] <= bus.imem_RD;
          wr_ptr        <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

  assign bus.ins_valid = (count != '0);
  assign bus.ins_data  = q_ins[rd_ptr];
  assign bus.ins_pc    = q_pc[rd_ptr];
  assign bus.state_o   = state;

  // Memory port: the loader owns it only while in LOAD.
  always_comb begin
    bus.imem_A  = fetch_pc;
    bus.imem_WE = 1'b0;
    bus.imem_WD = '0;
    bus.ld_ack  = 1'b0;
    if (state == S_LOAD) begin
      bus.imem_A  = bus.ld_addr & ~32'h3;
      bus.imem_WE = bus.ld_req;
      bus.imem_WD = bus.ld_data;
      bus.ld_ack  = bus.ld_req;
    end
  end

endmodule

// File: tb/tb_imem_fetch_controller.sv
module tb_imem_fetch_controller;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_fetch_controller_if bus();

  imem_fetch_controller #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural single-port memory: combinational read, write on the edge.
  logic [31:0] mem [64] = '{default: '0};
  assign bus.imem_RD = mem[bus.imem_A[7:2]];
  always @(posedge clk) if (bus.imem_WE) mem[bus.imem_A[7:2]] <= bus.imem_WD;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dw(input logic [31:0] a);
    return 32'hC0DE_0000 | a;
  endfunction

  typedef struct {
    logic        ld;
    logic [31:0] la;
    logic [31:0] ldat;
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic        rdy;
    logic [1:0]  e_st;
    logic        e_v;
    logic [31:0] e_pc;
    logic [31:0] e_d;
    logic [31:0] e_a;
    logic        e_ack;
    logic        e_we;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic ld, input logic [31:0] la, input logic [31:0] ldat,
                     input logic st, input logic rd, input logic [31:0] rpc, input logic rdy,
                     input logic [1:0] e_st, input logic e_v, input logic [31:0] e_pc,
                     input logic [31:0] e_d, input logic [31:0] e_a, input logic e_ack,
                     input logic e_we, input logic [31:0] e_wd);
    vec_t v;
    v.ld = ld; v.la = la; v.ldat = ldat; v.st = st; v.rd = rd; v.rpc = rpc; v.rdy = rdy;
    v.e_st = e_st; v.e_v = e_v; v.e_pc = e_pc; v.e_d = e_d; v.e_a = e_a;
    v.e_ack = e_ack; v.e_we = e_we; v.e_wd = e_wd;
    vq.push_back(v);
  endtask

  task automatic drive_idle();
    bus.ld_req = 1'b0; bus.ld_addr = '0; bus.ld_data = '0; bus.start = 1'b0;
    bus.redirect = 1'b0; bus.redirect_pc = '0; bus.ins_ready = 1'b0;
  endtask

  // Each row is one clock: inputs driven after the falling edge, outputs
  // checked 1 time unit later, then the rising edge consumes the inputs.
  task automatic run_vecs(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      bus.ld_req = vq[i].ld; bus.ld_addr = vq[i].la; bus.ld_data = vq[i].ldat;
      bus.start = vq[i].st; bus.redirect = vq[i].rd; bus.redirect_pc = vq[i].rpc;
      bus.ins_ready = vq[i].rdy;
      #1;
      chk($sformatf("%s%0d.state", tag, i), 32'(bus.state_o), 32'(vq[i].e_st));
      chk($sformatf("%s%0d.valid", tag, i), 32'(bus.ins_valid), 32'(vq[i].e_v));
      if (vq[i].e_v) begin
        chk($sformatf("%s%0d.pc", tag, i), bus.ins_pc, vq[i].e_pc);
        chk($sformatf("%s%0d.data", tag, i), bus.ins_data, vq[i].e_d);
      end
      chk($sformatf("%s%0d.imem_A", tag, i), bus.imem_A, vq[i].e_a);
      chk($sformatf("%s%0d.ld_ack", tag, i), 32'(bus.ld_ack), 32'(vq[i].e_ack));
      chk($sformatf("%s%0d.imem_WE", tag, i), 32'(bus.imem_WE), 32'(vq[i].e_we));
      chk($sformatf("%s%0d.imem_WD", tag, i), bus.imem_WD, vq[i].e_wd);
    end
    vq.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".state"},   32'(bus.state_o),   32'd0);
    chk({tag, ".valid"},   32'(bus.ins_valid), 32'd0);
    chk({tag, ".data"},    bus.ins_data,       32'd0);
    chk({tag, ".pc"},      bus.ins_pc,         32'd0);
    chk({tag, ".ld_ack"},  32'(bus.ld_ack),    32'd0);
    chk({tag, ".imem_WE"}, 32'(bus.imem_WE),   32'd0);
    chk({tag, ".imem_A"},  bus.imem_A,         32'd0);
    chk({tag, ".imem_WD"}, bus.imem_WD,        32'd0);
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Load five words at 0x0..0x10 (first ld_req cycle only enters LOAD).
    add(1, 32'h00, dw(32'h00), 0, 0, 0, 0,  0, 0, 0, 0, 32'h00, 0, 0, 32'h0);
    add(1, 32'h00, dw(32'h00), 0, 0, 0, 0,  2, 0, 0, 0, 32'h00, 1, 1, dw(32'h00));
    add(1, 32'h04, dw(32'h04), 0, 0, 0, 0,  2, 0, 0, 0, 32'h04, 1, 1, dw(32'h04));
    add(1, 32'h08, dw(32'h08), 0, 0, 0, 0,  2, 0, 0, 0, 32'h08, 1, 1, dw(32'h08));
    add(1, 32'h0E, dw(32'h0C), 0, 0, 0, 0,  2, 0, 0, 0, 32'h0C, 1, 1, dw(32'h0C));
    add(1, 32'h10, dw(32'h10), 0, 0, 0, 0,  2, 0, 0, 0, 32'h10, 1, 1, dw(32'h10));
    add(0, 32'h00, 32'h0,      0, 0, 0, 0,  2, 0, 0, 0, 32'h00, 0, 0, 32'h0);
    // Start and stream with ins_ready held high.
    add(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 32'h00, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 32'h00, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  1, 1, 32'h00, dw(32'h00), 32'h04, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  1, 1, 32'h04, dw(32'h04), 32'h08, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  1, 1, 32'h08, dw(32'h08), 32'h0C, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  1, 1, 32'h0C, dw(32'h0C), 32'h10, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  1, 1, 32'h10, dw(32'h10), 32'h14, 0, 0, 0);
    // Redirect back to 0, then ten cycles of backpressure.
    add(0, 0, 0, 0, 1, 32'h0, 0,  1, 1, 32'h14, 32'h0, 32'h18, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 32'h00, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  1, 1, 32'h00, dw(32'h00), 32'h04, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  1, 1, 32'h00, dw(32'h00), 32'h08, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  1, 1, 32'h00, dw(32'h00), 32'h0C, 0, 0, 0);
    for (int k = 0; k < 6; k++)
      add(0, 0, 0, 0, 0, 0, 0,  1, 1, 32'h00, dw(32'h00), 32'h10, 0, 0, 0);
    // Release: full queue pops and pushes in the same cycle.
    add(0, 0, 0, 0, 0, 0, 1,  1, 1, 32'h00, dw(32'h00), 32'h10, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  1, 1, 32'h04, dw(32'h04), 32'h14, 0, 0, 0);
    // Redirect to 0x42 while head is 0x8 and decode accepts it.
    add(0, 0, 0, 0, 1, 32'h42, 1,  1, 1, 32'h08, dw(32'h08), 32'h18, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 32'h40, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  1, 1, 32'h40, 32'h0, 32'h44, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  1, 1, 32'h40, 32'h0, 32'h48, 0, 0, 0);
    // Loader preempts fetch with three entries queued.
    add(1, 32'h20, 32'hBEEF_0020, 0, 0, 0, 0,  1, 1, 32'h40, 32'h0, 32'h4C, 0, 0, 0);
    add(1, 32'h20, 32'hBEEF_0020, 0, 0, 0, 0,  2, 0, 0, 0, 32'h20, 1, 1, 32'hBEEF_0020);
    add(0, 32'h20, 32'h0,         0, 0, 0, 0,  2, 0, 0, 0, 32'h20, 0, 0, 32'h0);
    add(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'h00, 0, 0, 0);
    // ld_req beats start in IDLE.
    add(1, 32'h24, 32'h5EED_0024, 1, 0, 0, 0,  0, 0, 0, 0, 32'h00, 0, 0, 0);
    add(1, 32'h24, 32'h5EED_0024, 0, 0, 0, 0,  2, 0, 0, 0, 32'h24, 1, 1, 32'h5EED_0024);
    add(0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 32'h00, 0, 0, 0);
    // Redirect ignored in IDLE; start fetches at RESET_PC.
    add(0, 0, 0, 1, 1, 32'h80, 0,  0, 0, 0, 0, 32'h00, 0, 0, 0);
    // Redirect to the top word: alignment and PC wrap to 0.
    add(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 1,  1, 0, 0, 0, 32'h00, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  1, 1, 32'hFFFF_FFFC, 32'h0, 32'h00, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  1, 1, 32'h00, dw(32'h00), 32'h04, 0, 0, 0);
    run_vecs("v");

    // Reset mid-stream with two entries queued.
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    #1;
    chk("mid.valid", 32'(bus.ins_valid), 32'd1);
    chk("mid.pc", bus.ins_pc, 32'h04);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");

`ifdef IMEM_HALT_EN
    // ebreak at 0x8 stops fetching after it is pushed; redirect resumes.
    add(1, 32'h08, EBREAK, 0, 0, 0, 0,  0, 0, 0, 0, 32'h00, 0, 0, 0);
    add(1, 32'h08, EBREAK, 0, 0, 0, 0,  2, 0, 0, 0, 32'h08, 1, 1, EBREAK);
    add(0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 32'h00, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 32'h00, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 32'h00, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  1, 1, 32'h00, dw(32'h00), 32'h04, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  1, 1, 32'h04, dw(32'h04), 32'h08, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  3, 1, 32'h08, EBREAK, 32'h0C, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  3, 0, 0, 0, 32'h0C, 0, 0, 0);
    add(0, 0, 0, 0, 1, 32'h0, 1,  3, 0, 0, 0, 32'h0C, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 32'h00, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  1, 1, 32'h00, dw(32'h00), 32'h04, 0, 0, 0);
    run_vecs("h");
`endif

    @(negedge clk);
    drive_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
